// File: rtl/timer_delay_scheduler_if.sv
// Bus between the delay scheduler and the Avalon interval timer s1 slave.
// The scheduler only writes; the timer reports completion via irq.
interface timer_delay_scheduler_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output irq
    );
endinterface

// File: rtl/timer_delay_scheduler.sv
// Round-robin sharing of one interval timer among NUM_REQ one-shot delay requesters.
// All outputs, including the timer bus, are registered from the next-state decision.
//
// state    | meaning
// IDLE     | arbitrate pending requests
// WR_PL    | bus shows period_l write
// WR_PH    | bus shows period_h write
// SETTLE   | no access, timer finishes reload/stop
// WR_CLR0  | clear any stale timeout
// WR_START | start one-shot count with irq enabled
// WAIT_IRQ | wait for timeout or cancel
// WR_CLR1  | clear the timeout that just fired
// ACK      | pulse ack to the winner
// WR_ABORT | stop the timer after a cancel
// WR_CLR2  | clear timeout after abort
module timer_delay_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [2:0]                 grant_id,
    timer_delay_scheduler_if.master    tmr
);

    typedef enum logic [3:0] {
        IDLE,
        WR_PL,
        WR_PH,
        SETTLE,
        WR_CLR0,
        WR_START,
        WAIT_IRQ,
        WR_CLR1,
        ACK,
        WR_ABORT,
        WR_CLR2
    } state_t;

    localparam logic [2:0]  ADDR_STATUS   = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL  = 3'd1;
    localparam logic [2:0]  ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0]  ADDR_PERIOD_H = 3'd3;
    localparam logic [15:0] CTRL_START    = 16'h0005;
    localparam logic [15:0] CTRL_STOP     = 16'h0008;

    state_t               state;
    logic [2:0]           rr_ptr;
    logic [15:0]          delay_hi;

    logic                 pick_found;
    logic [2:0]           pick_idx;
    logic [DELAY_W-1:0]   pick_delay;
    logic                 granted_req;
    logic [NUM_REQ-1:0]   grant_mask;
    logic [2:0]           rr_next;

    // First pass covers indices at or after rr_ptr, second pass wraps to the low ones.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[i] && (3'(i) >= rr_ptr)) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
                pick_delay = req_delay[i*DELAY_W +: DELAY_W];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && req[i]) begin
                pick_found = 1'b1;
                pick_idx   = 3'(i);
                pick_delay = req_delay[i*DELAY_W +: DELAY_W];
            end
        end
    end

    always_comb begin
        granted_req = 1'b0;
        grant_mask  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                granted_req   = req[i];
                grant_mask[i] = 1'b1;
            end
        end
        rr_next = (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            delay_hi       <= '0;
            grant_id       <= '0;
            ack            <= '0;
            busy           <= 1'b0;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tmr.address    <= '0;
            tmr.writedata  <= '0;
        end else begin
            ack            <= '0;
            busy           <= 1'b1;
            tmr.chipselect <= 1'b0;
            tmr.write_n    <= 1'b1;
            tmr.address    <= '0;
            tmr.writedata  <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        delay_hi <= pick_delay[31:16];
                        if (pick_delay == '0) begin
                            state <= ACK;
                            ack   <= (NUM_REQ)'(1) << pick_idx;
                        end else begin
                            state          <= WR_PL;
                            tmr.chipselect <= 1'b1;
                            tmr.write_n    <= 1'b0;
                            tmr.address    <= ADDR_PERIOD_L;
                            tmr.writedata  <= pick_delay[15:0];
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                WR_PL: begin
                    state          <= WR_PH;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_PERIOD_H;
                    tmr.writedata  <= delay_hi;
                end
                WR_PH: state <= SETTLE;
                SETTLE: begin
                    state          <= WR_CLR0;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_STATUS;
                end
                WR_CLR0: begin
                    state          <= WR_START;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_CONTROL;
                    tmr.writedata  <= CTRL_START;
                end
                WR_START: state <= WAIT_IRQ;
                WAIT_IRQ: begin
                    // A timeout wins over a cancel arriving in the same cycle.
                    if (tmr.irq) begin
                        state          <= WR_CLR1;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_STATUS;
                    end else if (!granted_req) begin
                        state          <= WR_ABORT;
                        tmr.chipselect <= 1'b1;
                        tmr.write_n    <= 1'b0;
                        tmr.address    <= ADDR_CONTROL;
                        tmr.writedata  <= CTRL_STOP;
                    end
                end
                WR_CLR1: begin
                    state <= ACK;
                    ack   <= grant_mask;
                end
                ACK: begin
                    state  <= IDLE;
                    rr_ptr <= rr_next;
                    busy   <= 1'b0;
                end
                WR_ABORT: begin
                    state          <= WR_CLR2;
                    tmr.chipselect <= 1'b1;
                    tmr.write_n    <= 1'b0;
                    tmr.address    <= ADDR_STATUS;
                end
                WR_CLR2: begin
                    state  <= IDLE;
                    rr_ptr <= rr_next;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/timer_delay_scheduler.md
# timer_delay_scheduler

Sequencer and arbiter that shares the single 16-bit-register Avalon interval timer between NUM_REQ hardware requesters. Each requester asks for a one-shot delay of a given number of clocks. The block grants the timer round-robin, programs period/control over the timer's slave port, waits for its irq, clears the timeout, and acknowledges the winner. It sits between the requesting datapath blocks and the timer's s1 slave, replacing CPU-driven timer programming for those users.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DELAY_W, 32, width of each requested delay (fixed to timer counter width)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request per requester; held until ack or withdrawn to cancel
- req_delay  in  NUM_REQ*DELAY_W  delay for requester i at bits [i*32+31:i*32]; sampled at grant
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever the FSM is not IDLE
- grant_id  out  3  index of current/last granted requester
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select, high only in write states
- tmr_write_n  out  1  active-low write strobe, low only in write states
- tmr_writedata  out  16  timer write data
- tmr_irq  in  1  timer interrupt (level, held until status write)

## Operation
- Timer map used: 0 status (any write clears timeout), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period_l, 3 period_h. No reads are issued; tmr_readdata is not used.
- FSM states: IDLE, WR_PL, WR_PH, SETTLE, WR_CLR0, WR_START, WAIT_IRQ, WR_CLR1, ACK, WR_ABORT, WR_CLR2.
- IDLE: if any req bit is set, pick the first set bit at or after rr_ptr (wrapping), then latch grant_id and delay. If delay==0, go to ACK directly without touching the timer. Otherwise go to WR_PL.
- WR_PL: write addr 2, data delay[15:0]. WR_PH: write addr 3, data delay[31:16]. SETTLE: no access; lets the timer's force-reload and stop complete.
- WR_CLR0: write addr 0, data 0, clearing any stale timeout. WR_START: write addr 1, data 0x0005 (ITO, START, one-shot).
- WAIT_IRQ: if tmr_irq is high, go to WR_CLR1. Otherwise, if req[grant_id] is low (cancel), go to WR_ABORT. irq takes priority over cancel in the same cycle.
- WR_CLR1: write addr 0. ACK: ack[grant_id]=1 for one cycle, rr_ptr=grant_id+1 mod NUM_REQ, then IDLE.
- WR_ABORT: write addr 1, data 0x0008 (STOP, ITO off). WR_CLR2: write addr 0. Then IDLE with no ack, and rr_ptr advances as in ACK.
- Timer write accesses are single-cycle: chipselect=1, write_n=0, address/data valid. The timer has no waitrequest.
- Idle bus values: chipselect=0, write_n=1, address=0, writedata=0.

## Timing
- Reset values: ack=0, busy=0, grant_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0. Internal state: FSM=IDLE, rr_ptr=0.
- All outputs are registered. The first write appears the cycle after the IDLE cycle that saw req.
- Request to START write: IDLE, PL, PH, SETTLE, CLR0, then START in the 6th cycle. The START write happens 5 cycles after req is first seen in IDLE.
- irq seen in WAIT_IRQ to ack: CLR1 in the next cycle, ack in the following cycle (2 cycles).
- delay==0: ack asserts 1 cycle after the IDLE grant cycle.
- req is re-sampled only in IDLE. After ack, a requester must drop req in the ack cycle or it re-arbitrates. Back-to-back grants are therefore separated by at least one IDLE cycle.
- Reset mid-operation: the FSM returns to IDLE immediately and the bus returns to idle values. The timer is not touched, so a running count may later assert tmr_irq. That irq is ignored in IDLE, and the stale timeout is cleared by WR_CLR0 of the next grant.
- tmr_irq asserted outside WAIT_IRQ is ignored.

## Test plan
- Single request: req[1]=1, delay=0x0001_0002. Expect writes (2,0x0002), (3,0x0001), (0,0), (1,0x0005) on consecutive cycles, with one gap cycle after the addr-3 write. Then force tmr_irq: expect a write (0,·), then ack[1] one cycle later, grant_id=1.
- Round-robin: req=4'b1111 held, re-asserted after each ack. Expect grant order 0,1,2,3,0, with rr_ptr wrap verified.
- Zero delay: req[2]=1, delay=0. Expect ack[2] on the 2nd cycle with no timer access at all.
- Cancel: req[3]=1, delay=1000; drop req[3] while in WAIT_IRQ. Expect writes (1,0x0008), then (0,·), with no ack[3], busy low afterwards. Also raise irq and cancel in the same cycle: expect the normal ack path.
- Stale irq: hold tmr_irq high in IDLE, then issue a request. Expect no early ack; WR_CLR0 is issued and ack follows only after irq is seen in WAIT_IRQ.
- Reset in WAIT_IRQ: assert reset. Expect all outputs at reset values in the same cycle, busy=0, and a clean new grant after release.
